// File: rtl/engage_scheduler.sv
// Launcher arbiter: picks the highest-threat locked, not-yet-engaged track,
// arms, holds a fire request until acknowledged, then cools down.
module engage_scheduler #(
  parameter int          NUM_TRK         = 4,
  parameter logic [15:0] ARM_CYCLES      = 16'd1000,
  parameter logic [15:0] COOLDOWN_CYCLES = 16'd5000,
  parameter logic [15:0] ACK_TIMEOUT     = 16'd2000,
  localparam int         ID_W            = $clog2(NUM_TRK)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_TRK-1:0]     lock_active,
  input  logic [2*NUM_TRK-1:0]   threat_pri,
  input  logic                   engage_en,
  input  logic                   launcher_ready,
  input  logic                   fire_ack,
  output logic                   fire_req,
  output logic [ID_W-1:0]        fire_trk_id,
  output logic                   busy,
  output logic [NUM_TRK-1:0]     engaged_mask,
  output logic                   abort_pulse,
  output logic                   fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ARM, S_FIRE, S_COOLDOWN, S_FAULT
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ID_W-1:0]     sel_id_q, sel_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_TRK-1:0]  mask_q, mask_d;
  logic                abort_q, abort_d;

  logic [NUM_TRK-1:0]      elig;
  logic [NUM_TRK-1:0][1:0] pri_arr;
  logic [NUM_TRK-1:0]      set_bit;
  logic                    best_found;
  logic [1:0]              best_pri;
  logic [ID_W-1:0]         best_id;
  logic [15:0]             cnt_inc;

  assign elig    = lock_active & ~mask_q;
  assign pri_arr = threat_pri;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Round-robin search from rr_ptr; strict '>' keeps the first hit on ties.
  always_comb begin
    best_found = 1'b0;
    best_pri   = 2'd0;
    best_id    = rr_ptr_q;
    for (int j = 0; j < NUM_TRK; j++) begin
      int k;
      k = int'(rr_ptr_q) + j;
      if (k >= NUM_TRK) k = k - NUM_TRK;
      if (elig[k] && (!best_found || pri_arr[k] > best_pri)) begin
        best_found = 1'b1;
        best_pri   = pri_arr[k];
        best_id    = ID_W'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_id_d = sel_id_q;
    rr_ptr_d = rr_ptr_q;
    abort_d  = 1'b0;
    set_bit  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (engage_en && launcher_ready && |elig) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (|elig) begin
          sel_id_d = best_id;
          cnt_d    = '0;
          state_d  = S_ARM;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ARM: begin
        if (!lock_active[sel_id_q] || !engage_en) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == ARM_CYCLES - 16'd1) begin
          cnt_d   = '0;
          state_d = S_FIRE;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      S_FIRE: begin
        if (fire_ack) begin
          set_bit[sel_id_q] = 1'b1;
          rr_ptr_d = (sel_id_q == ID_W'(NUM_TRK-1)) ? '0 : sel_id_q + 1'b1;
          cnt_d    = '0;
          state_d  = S_COOLDOWN;
        end else if (cnt_q == ACK_TIMEOUT - 16'd1) begin
          state_d  = S_FAULT;
        end else begin
          cnt_d    = cnt_inc;
        end
      end
      S_COOLDOWN: begin
        if (cnt_q == COOLDOWN_CYCLES - 16'd1) state_d = S_IDLE;
        else                                  cnt_d   = cnt_inc;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // A lock loss clears the mask bit even in the cycle it would be set.
  assign mask_d = (mask_q | set_bit) & lock_active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_id_q <= '0;
      rr_ptr_q <= '0;
      mask_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_id_q <= sel_id_d;
      rr_ptr_q <= rr_ptr_d;
      mask_q   <= mask_d;
      abort_q  <= abort_d;
    end
  end

  assign fire_req     = (state_q == S_FIRE);
  assign fire_trk_id  = (state_q == S_FIRE) ? sel_id_q : '0;
  assign busy         = (state_q != S_IDLE);
  assign engaged_mask = mask_q;
  assign abort_pulse  = abort_q;
  assign fault        = (state_q == S_FAULT);

endmodule

// File: tb/tb_engage_scheduler.sv
// Directed bench for engage_scheduler with short arm/cooldown/timeout values.
module tb_engage_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] lock_active;
  logic [7:0] threat_pri;
  logic       engage_en, launcher_ready, fire_ack;
  logic       fire_req, busy, abort_pulse, fault;
  logic [1:0] fire_trk_id;
  logic [3:0] engaged_mask;

  int n_chk = 0;
  int n_err = 0;
  int ncyc;

  engage_scheduler #(
    .NUM_TRK(4), .ARM_CYCLES(16'd4), .COOLDOWN_CYCLES(16'd3), .ACK_TIMEOUT(16'd5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .lock_active(lock_active), .threat_pri(threat_pri),
    .engage_en(engage_en), .launcher_ready(launcher_ready), .fire_ack(fire_ack),
    .fire_req(fire_req), .fire_trk_id(fire_trk_id), .busy(busy),
    .engaged_mask(engaged_mask), .abort_pulse(abort_pulse), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    lock_active = '0; threat_pri = '0;
    engage_en = 1'b0; launcher_ready = 1'b0; fire_ack = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic wait_fire(input int max_cyc);
    int n;
    n = 0;
    while (!fire_req && n < max_cyc) begin
      tick();
      n++;
    end
    chk("fire_seen", fire_req, 1);
  endtask

  task automatic ack_once();
    fire_ack = 1'b1;
    tick();
    fire_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_fire_req", fire_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mask", engaged_mask, 0);
    chk("rst_abort", abort_pulse, 0);
    chk("rst_fault", fault, 0);
    chk("rst_trk", fire_trk_id, 0);

    // Single track: fire_req appears on the 6th edge after lock
    lock_active = 4'b0010; threat_pri = 8'b00_00_10_00;
    engage_en = 1'b1; launcher_ready = 1'b1;
    tick();
    chk("t1_busy_sel", busy, 1);
    tick(4);
    chk("t1_no_fire_e5", fire_req, 0);
    tick();
    chk("t1_fire_e6", fire_req, 1);
    chk("t1_trk", fire_trk_id, 1);
    tick();
    chk("t1_fire_hold", fire_req, 1);
    ack_once();
    chk("t1_fire_drop", fire_req, 0);
    chk("t1_mask", engaged_mask, 4'b0010);
    tick(2);
    chk("t1_busy_cd", busy, 1);
    tick();
    chk("t1_idle", busy, 0);
    tick(10);
    chk("t1_no_refire", fire_req, 0);
    chk("t1_stay_idle", busy, 0);

    // Priority with round-robin tie break
    do_reset();
    lock_active = 4'b1111; threat_pri = 8'b11_01_11_00;
    engage_en = 1'b1; launcher_ready = 1'b1;
    wait_fire(20);
    chk("t2_first_trk", fire_trk_id, 1);
    ack_once();
    chk("t2_mask1", engaged_mask, 4'b0010);
    wait_fire(20);
    chk("t2_second_trk", fire_trk_id, 3);
    ack_once();
    chk("t2_mask2", engaged_mask, 4'b1010);

    // Abort by lock loss in ARM
    do_reset();
    lock_active = 4'b0100; engage_en = 1'b1; launcher_ready = 1'b1;
    tick(3);
    lock_active = 4'b0000;
    tick();
    chk("t3_abort_lock", abort_pulse, 1);
    chk("t3_idle_lock", busy, 0);
    tick();
    chk("t3_abort_1cyc", abort_pulse, 0);
    chk("t3_nofire_lock", fire_req, 0);
    chk("t3_mask_lock", engaged_mask, 0);

    // Abort by engage_en drop in ARM
    lock_active = 4'b0100;
    tick(3);
    engage_en = 1'b0;
    tick();
    chk("t3_abort_en", abort_pulse, 1);
    chk("t3_idle_en", busy, 0);
    tick();
    chk("t3_abort_en_1cyc", abort_pulse, 0);
    tick(6);
    chk("t3_nofire_en", fire_req, 0);
    chk("t3_mask_en", engaged_mask, 0);

    // Ack timeout -> sticky fault
    do_reset();
    lock_active = 4'b0001; engage_en = 1'b1; launcher_ready = 1'b1;
    wait_fire(20);
    tick(4);
    chk("t4_fire_before_to", fire_req, 1);
    tick();
    chk("t4_fault", fault, 1);
    chk("t4_fire_low", fire_req, 0);
    chk("t4_busy", busy, 1);
    ack_once();
    tick(3);
    chk("t4_fault_sticky", fault, 1);
    do_reset();
    chk("t4_rst_fault", fault, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_fire", fire_req, 0);

    // Ack coinciding with lock loss: mask bit cleared, still cooldown
    lock_active = 4'b0001; engage_en = 1'b1; launcher_ready = 1'b1;
    wait_fire(20);
    fire_ack = 1'b1; lock_active = 4'b0000;
    tick();
    fire_ack = 1'b0;
    chk("t5_mask_clr", engaged_mask, 0);
    chk("t5_cd_busy", busy, 1);
    chk("t5_cd_nofire", fire_req, 0);
    chk("t5_cd_nofault", fault, 0);

    // Ack on the timeout cycle wins
    do_reset();
    lock_active = 4'b0001; engage_en = 1'b1; launcher_ready = 1'b1;
    wait_fire(20);
    tick(4);
    fire_ack = 1'b1;
    tick();
    fire_ack = 1'b0;
    chk("t5_to_ack_fault", fault, 0);
    chk("t5_to_ack_fire", fire_req, 0);
    chk("t5_to_ack_busy", busy, 1);
    chk("t5_to_ack_mask", engaged_mask, 4'b0001);

    // Asynchronous reset in the middle of FIRE
    do_reset();
    lock_active = 4'b0010; engage_en = 1'b1; launcher_ready = 1'b1;
    wait_fire(20);
    ncyc = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_fire", fire_req, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_mask", engaged_mask, 0);
    tick();
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
